branch_resolve_unit: RTL

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Resolves one conditional branch at a time. The branch is latched on accept,
// evaluated for exactly one cycle (out_valid pulse), and for a taken, aligned
// branch a fetch redirect is held until fetch accepts it.
// Optional feature macro: BRANCH_STATS_EN adds stat_branches / stat_taken
// counters. The default build (macro undefined) has no counter ports or logic.
module branch_resolve_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [11:0] imm,
  input  logic [2:0]  branch_control,
  output logic        out_valid,
  output logic        out_taken,
  output logic [31:0] out_target,
  output logic        out_misaligned,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_taken
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_REDIRECT
  } state_e;

  // Branch-control encoding shared with decode (funct3 layout).
  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_ctrl_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [11:0] imm;
    logic [2:0]  ctrl;
  } br_ops_t;

  state_e      state_q, state_d;
  br_ops_t     ops_q, ops_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic [31:0] imm_ext;
  logic [31:0] target_taken;
  logic [31:0] fall_through;
  logic        cond;
  logic        target_misaligned;
  logic        is_eval;

  // Branch condition and both candidate next-PCs from the latched operands only.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    cond         = 1'b0;
    imm_ext      = {{19{ops_q.imm[11]}}, ops_q.imm, 1'b0};
    target_taken = ops_q.pc + imm_ext;
    fall_through = ops_q.pc + 32'd4;
    case (ops_q.ctrl)
      BR_BNE:  cond = (ops_q.rs1 != ops_q.rs2);
      BR_BLT:  cond = ($signed(ops_q.rs1) <  $signed(ops_q.rs2));
      BR_BGE:  cond = ($signed(ops_q.rs1) >= $signed(ops_q.rs2));
      BR_BLTU: cond = (ops_q.rs1 <  ops_q.rs2);
      BR_BGEU: cond = (ops_q.rs1 >= ops_q.rs2);
      default: cond = (ops_q.rs1 == ops_q.rs2);  // BEQ and unlisted codes
    endcase
    target_misaligned = (target_taken[1:0] != 2'b00);
  end

  // Next-state logic: accept in IDLE, single-cycle EVAL, hold REDIRECT until fetch takes it.
  always_comb begin
    state_d       = state_q;
    ops_d         = ops_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ops_d   = '{pc: pc, rs1: rs1_data, rs2: rs2_data, imm: imm, ctrl: branch_control};
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (cond && !target_misaligned) begin
          redirect_pc_d = target_taken;
          state_d       = S_REDIRECT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REDIRECT: begin
        if (redirect_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and operand registers; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      // NOTE: operand and redirect registers are reset too, because they drive visible outputs.
      state_q       <= S_IDLE;
      ops_q         <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      ops_q         <= ops_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign is_eval        = (state_q == S_EVAL);
  assign in_ready       = (state_q == S_IDLE);
  assign out_valid      = is_eval;
  assign out_taken      = is_eval && cond;
  assign out_misaligned = is_eval && cond && target_misaligned;
  assign out_target     = is_eval ? (cond ? target_taken : fall_through) : 32'd0;
  assign redirect_valid = (state_q == S_REDIRECT);
  assign redirect_pc    = redirect_pc_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_taken_q, stat_taken_d;

  // Wrapping counters of resolved and taken branches.
  always_comb begin
    stat_branches_d = stat_branches_q + {31'd0, out_valid};
    stat_taken_d    = stat_taken_q + {31'd0, out_taken};
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_q <= '0;
      stat_taken_q    <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_taken_q    <= stat_taken_d;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_taken    = stat_taken_q;
`endif

endmodule
